// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU register-file family.
// Holds the clear-engine state encoding, default widths and a constant-safe clog2.
package cpu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: R0 gating, range check, optional write bypass.
// Latency 1 cycle; no read enable, output updates every cycle.
module reg_file_rd_port
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = 16,
  parameter int R0_ZERO  = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              rd_ba_i,
  input  logic [DATA_W-1:0] regs_i [NUM_REGS],
  input  logic              wr_ok_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0] stored;
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              in_range;

  assign in_range = {1'b0, rd_addr_i} < NUM_REGS_W;

  always_comb begin
    stored = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rd_addr_i == ADDR_W'(r)) stored = regs_i[r];
    end
  end

  // Priority order matters: BA gating beats bypass on R0.
  always_comb begin
    rd_data_d = stored;
    if ((R0_ZERO != 0) && rd_ba_i && (rd_addr_i == '0)) begin
      rd_data_d = '0;
    end else if (!in_range) begin
      rd_data_d = '0;
    end else if ((BYPASS != 0) && wr_ok_i && (wr_addr_i == rd_addr_i)) begin
      rd_data_d = wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rd_data_q <= '0;
    else         rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with one write port and a sequential clear engine.
// Reads land 1 cycle after address; writes during clear or out of range are dropped and flagged.
module reg_file_mp
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = 16,
  parameter int NUM_RD   = 2,
  parameter int R0_ZERO  = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_ba,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     clr_done,
  output logic                     wr_drop
);

  localparam int              IDX_W      = clog2(NUM_REGS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  clr_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wr_drop_q, wr_drop_d;
  logic              wr_ok;

  assign busy     = (state_q == ST_CLEAR);
  assign clr_done = (state_q == ST_DONE);
  assign wr_drop  = wr_drop_q;

  assign wr_ok     = wr_en && !busy && ({1'b0, wr_addr} < NUM_REGS_W);
  assign wr_drop_d = wr_en && !wr_ok;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // wr_ok is already false while clearing, so the two branches never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (busy && (idx_q == IDX_W'(r)))              regs_q[r] <= '0;
        else if (wr_ok && (wr_addr == ADDR_W'(r)))     regs_q[r] <= wr_data;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    reg_file_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS),
      .R0_ZERO  (R0_ZERO),
      .BYPASS   (BYPASS)
    ) u_rd (
      .clk_i     (clk),
      .reset_i   (reset),
      .rd_addr_i (rd_addr[p*ADDR_W +: ADDR_W]),
      .rd_ba_i   (rd_ba[p]),
      .regs_i    (regs_q),
      .wr_ok_i   (wr_ok),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_data_o (rd_data[p*DATA_W +: DATA_W])
    );
  end

endmodule
